// File: rtl/disp_scan_ctrl_if.sv
// Bundles the control and display signals of the multiplexed 7-segment scanner.
// Latency: none, this is wiring only.
// Backpressure: none. LOAD is a fire-and-forget strobe with no ready signal.
// Ports: ENABLE, LOAD, DIGIT_IN, DOT_IN and LZB run from master to slave.
//        SEG_SELECT, HEX_OUT and FRAME_DONE run from slave to master.
interface disp_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      ENABLE;
  logic                      LOAD;
  logic [4*NUM_DIGITS-1:0]   DIGIT_IN;
  logic [NUM_DIGITS-1:0]     DOT_IN;
  logic                      LZB;
  logic [NUM_DIGITS-1:0]     SEG_SELECT;
  logic [7:0]                HEX_OUT;
  logic                      FRAME_DONE;

  modport master (
    output ENABLE, LOAD, DIGIT_IN, DOT_IN, LZB,
    input  SEG_SELECT, HEX_OUT, FRAME_DONE
  );

  modport slave (
    input  ENABLE, LOAD, DIGIT_IN, DOT_IN, LZB,
    output SEG_SELECT, HEX_OUT, FRAME_DONE
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Scans NUM_DIGITS 7-segment digits, with a frame-synchronous double buffer for the displayed value.
// Latency: outputs are registered and show the new digit one cycle after the divider tick.
// Backpressure: none. LOAD is always accepted, and the last LOAD before a frame boundary wins.
// Ports: CLK, RESET (async, active high) and bus (slave modport).
//        The bus carries the enable, load, data and blanking inputs plus the select, segment and frame outputs.
module disp_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  disp_scan_ctrl_if.slave bus
);
  localparam int   CW  = $clog2(REFRESH_DIV);
  localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] act_dig, act_dig_nxt, pnd_dig, pnd_dig_nxt;
  logic [NUM_DIGITS-1:0]   act_dot, act_dot_nxt, pnd_dot, pnd_dot_nxt;
  logic                    pnd_vld, pnd_vld_nxt;
  logic                    tick, boundary;
  logic [NUM_DIGITS-1:0]   sel_int;
  logic [7:0]              hex_int;
  logic [NUM_DIGITS-1:0]   seg_q;
  logic [7:0]              hex_q;
  logic                    frame_q;

  // Segment decoder. The output is active high and ordered g..a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Next-state logic for the divider, the index and the double buffer.
  always_comb begin
    tick        = bus.ENABLE && (cnt == CW'(REFRESH_DIV - 1));
    boundary    = tick && (idx == IW'(NUM_DIGITS - 1));
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    act_dig_nxt = act_dig;
    act_dot_nxt = act_dot;
    pnd_dig_nxt = pnd_dig;
    pnd_dot_nxt = pnd_dot;
    pnd_vld_nxt = pnd_vld;
    if (bus.ENABLE) cnt_nxt = tick ? '0 : cnt + CW'(1);
    if (tick)       idx_nxt = boundary ? '0 : idx + IW'(1);
    if (boundary) begin
      // A LOAD in the boundary cycle is newer than anything pending, so it goes straight to active.
      if (bus.LOAD) begin
        act_dig_nxt = bus.DIGIT_IN;
        act_dot_nxt = bus.DOT_IN;
      end else if (pnd_vld) begin
        act_dig_nxt = pnd_dig;
        act_dot_nxt = pnd_dot;
      end
      pnd_vld_nxt = 1'b0;
    end else if (bus.LOAD) begin
      pnd_dig_nxt = bus.DIGIT_IN;
      pnd_dot_nxt = bus.DOT_IN;
      pnd_vld_nxt = 1'b1;
    end
  end

  // The output image is built from the next-state index and buffer.
  // This lets the registered outputs change on the same edge that moves the index.
  always_comb begin
    logic       upper_zero;
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    sel_int    = '0;
    hex_int    = '0;
    upper_zero = 1'b1;
    nib        = 4'h0;
    dp         = 1'b0;
    blank      = 1'b0;
    // Walk from the most significant digit down.
    // At digit k, upper_zero is set when nibbles k..N-1 are all zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (act_dig_nxt[4*k +: 4] == 4'h0);
      if (idx_nxt == IW'(k)) begin
        sel_int[k] = 1'b1;
        nib        = act_dig_nxt[4*k +: 4];
        dp         = act_dot_nxt[k];
        blank      = bus.LZB && (k != 0) && upper_zero;
      end
    end
    if (bus.ENABLE) hex_int = {dp, blank ? 7'h00 : hex_glyph(nib)};
    else            sel_int = '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      idx     <= '0;
      act_dig <= '0;
      act_dot <= '0;
      pnd_dig <= '0;
      pnd_dot <= '0;
      pnd_vld <= 1'b0;
      seg_q   <= {NUM_DIGITS{POL}};
      hex_q   <= {8{POL}};
      frame_q <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      act_dig <= act_dig_nxt;
      act_dot <= act_dot_nxt;
      pnd_dig <= pnd_dig_nxt;
      pnd_dot <= pnd_dot_nxt;
      pnd_vld <= pnd_vld_nxt;
      // Polarity is applied only here. Both planes stay active high internally.
      seg_q   <= {NUM_DIGITS{POL}} ^ sel_int;
      hex_q   <= {8{POL}} ^ hex_int;
      frame_q <= boundary;
    end
  end

  assign bus.SEG_SELECT = seg_q;
  assign bus.HEX_OUT    = hex_q;
  assign bus.FRAME_DONE = frame_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4 and ACTIVE_LOW=1.
// Latency: samples are taken on the falling edge. nK means the K-th falling edge after reset release.
// Backpressure: not applicable. All stimulus is a fixed timeline.
module tb_disp_scan_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  disp_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  disp_scan_ctrl #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .ACTIVE_LOW (1)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] seg, input logic [7:0] hex,
                            input logic fd);
    chk({tag, ".sel"}, {4'h0, bus.SEG_SELECT}, {4'h0, seg});
    chk({tag, ".hex"}, bus.HEX_OUT, hex);
    chk({tag, ".fd"},  {7'h0, bus.FRAME_DONE}, {7'h0, fd});
  endtask

  initial begin
    RESET        = 1'b1;
    bus.ENABLE   = 1'b1;
    bus.LOAD     = 1'b0;
    bus.DIGIT_IN = 16'h0000;
    bus.DOT_IN   = 4'b0000;
    bus.LZB      = 1'b0;
    cyc(2);
    expect_out("reset", 4'b1111, 8'hFF, 1'b0);
    RESET = 1'b0;                                  // n0
    cyc(1);  expect_out("scan_d0",  4'b1110, 8'hC0, 1'b0);  // n1
    cyc(3);  expect_out("scan_d1",  4'b1101, 8'hC0, 1'b0);  // n4
    cyc(4);  expect_out("scan_d2",  4'b1011, 8'hC0, 1'b0);  // n8
    cyc(4);  expect_out("scan_d3",  4'b0111, 8'hC0, 1'b0);  // n12
    cyc(4);  expect_out("frame1",   4'b1110, 8'hC0, 1'b1);  // n16
    cyc(1);  expect_out("fd_pulse", 4'b1110, 8'hC0, 1'b0);  // n17

    // A mid-frame load must not disturb the frame that is currently showing.
    cyc(1);                                                 // n18
    bus.LOAD = 1'b1; bus.DIGIT_IN = 16'h1234; bus.DOT_IN = 4'b0000;
    cyc(1);  bus.LOAD = 1'b0;                               // n19
    cyc(1);  expect_out("noTear",   4'b1101, 8'hC0, 1'b0);  // n20
    cyc(12); expect_out("ld_d0",    4'b1110, 8'h99, 1'b1);  // n32
    cyc(4);  expect_out("ld_d1",    4'b1101, 8'hB0, 1'b0);  // n36
    cyc(8);  expect_out("ld_d3",    4'b0111, 8'hF9, 1'b0);  // n44

    // Two loads before the boundary. Only the second one may appear.
    cyc(1);                                                 // n45
    bus.LOAD = 1'b1; bus.DIGIT_IN = 16'h1111;
    cyc(1);  bus.DIGIT_IN = 16'hABCD;                       // n46
    cyc(1);  bus.LOAD = 1'b0;                               // n47
    expect_out("lw_hold",  4'b0111, 8'hF9, 1'b0);
    cyc(1);  expect_out("lw_d0",    4'b1110, 8'hA1, 1'b1);  // n48

    // Leading-zero blanking, with the decimal point lit on digit 2.
    cyc(2);                                                 // n50
    bus.LOAD = 1'b1; bus.DIGIT_IN = 16'h0070; bus.DOT_IN = 4'b0100; bus.LZB = 1'b1;
    cyc(1);  bus.LOAD = 1'b0;                               // n51
    cyc(1);  expect_out("lw_d1",    4'b1101, 8'hC6, 1'b0);  // n52
    cyc(12); expect_out("lzb_d0",   4'b1110, 8'hC0, 1'b1);  // n64
    cyc(4);  expect_out("lzb_d1",   4'b1101, 8'hF8, 1'b0);  // n68
    cyc(4);  expect_out("lzb_d2",   4'b1011, 8'h7F, 1'b0);  // n72
    cyc(4);  expect_out("lzb_d3",   4'b0111, 8'hFF, 1'b0);  // n76

    // A load in the boundary cycle goes directly to the active buffer.
    cyc(3);                                                 // n79
    bus.LOAD = 1'b1; bus.DIGIT_IN = 16'h0009; bus.DOT_IN = 4'b0000;
    cyc(1);  bus.LOAD = 1'b0;                               // n80
    expect_out("bnd_load", 4'b1110, 8'h90, 1'b1);

    // Disable for 10 cycles with the counter at 1. Digit 0 then finishes its last 2 cycles.
    cyc(1);  bus.ENABLE = 1'b0;                             // n81
    cyc(1);  expect_out("dis_a",    4'b1111, 8'hFF, 1'b0);  // n82
    cyc(8);  expect_out("dis_b",    4'b1111, 8'hFF, 1'b0);  // n90
    cyc(1);  bus.ENABLE = 1'b1;                             // n91
    cyc(1);  expect_out("en_a",     4'b1110, 8'h90, 1'b0);  // n92
    cyc(1);  expect_out("en_b",     4'b1110, 8'h90, 1'b0);  // n93
    cyc(1);  expect_out("en_d1",    4'b1101, 8'hFF, 1'b0);  // n94

    // A reset mid-frame with a load pending must discard the pending value.
    cyc(2);                                                 // n96
    bus.LOAD = 1'b1; bus.DIGIT_IN = 16'h5555;
    cyc(1);  bus.LOAD = 1'b0;                               // n97
    cyc(1);  expect_out("pre_rst",  4'b1011, 8'hFF, 1'b0);  // n98
    RESET = 1'b1; bus.LZB = 1'b0;
    #1;      expect_out("rst_async", 4'b1111, 8'hFF, 1'b0);
    cyc(2);  expect_out("rst_hold", 4'b1111, 8'hFF, 1'b0);
    RESET = 1'b0;                                           // n0'
    cyc(1);  expect_out("rr_d0",    4'b1110, 8'hC0, 1'b0);  // n1'
    cyc(2);  expect_out("rr_d0b",   4'b1110, 8'hC0, 1'b0);  // n3'
    cyc(1);  expect_out("rr_d1",    4'b1101, 8'hC0, 1'b0);  // n4'
    cyc(12); expect_out("rr_frame", 4'b1110, 8'hC0, 1'b1);  // n16'
    cyc(4);  expect_out("rr_lost",  4'b1101, 8'hC0, 1'b0);  // n20'

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, CLK cycles each digit is displayed (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 = anodes and segments driven low-active, 0 = high-active.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: CLK and RESET, as the rest of the codebase names them.
REQ-005 CLK  input  1  system clock, all state on rising edge.
REQ-006 RESET  input  1  asynchronous active-high reset.
REQ-007 ENABLE  input  1  scan enable; low = display dark, scan frozen.
REQ-008 LOAD  input  1  one-cycle strobe capturing DIGIT_IN/DOT_IN.
REQ-009 DIGIT_IN  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 least significant.
REQ-010 DOT_IN  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-011 LZB  input  1  leading-zero blanking mode.
REQ-012 SEG_SELECT  output  NUM_DIGITS  one-hot digit select (at ACTIVE_LOW polarity).
REQ-013 HEX_OUT  output  8  bit7 = dp, bits6..0 = segments g..a (at ACTIVE_LOW polarity).
REQ-014 FRAME_DONE  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Divider counter SHALL count 0..REFRESH_DIV-1 while ENABLE=1, wrap to 0, asserting an internal tick on the terminal count.
REQ-016 On tick, digit index SHALL advance k -> k+1, wrapping NUM_DIGITS-1 -> 0; frame boundary = tick with index NUM_DIGITS-1.
REQ-017 SEG_SELECT and HEX_OUT SHALL be registered, reflecting the new index exactly one cycle after the tick.
REQ-018 LOAD SHALL copy DIGIT_IN/DOT_IN into a pending buffer and set a pending flag; a further LOAD before the boundary overwrites pending (last wins).
REQ-019 At frame boundary with pending set, pending SHALL transfer to the active buffer and pending clear; active never changes mid-frame (no tearing).
REQ-020 LOAD coincident with frame boundary SHALL transfer the new DIGIT_IN/DOT_IN directly to active and leave pending clear.
REQ-021 FRAME_DONE SHALL pulse high for exactly one cycle, in the cycle after each frame boundary tick.
REQ-022 Decoder SHALL map nibbles 0-F to standard hex glyphs (0-9, A, b, C, d, E, F).
REQ-023 With LZB=1, digit k>0 SHALL be blanked (segments g..a off) when its nibble and every more-significant nibble are 0; digit 0 never blanked; dp still follows DOT_IN.
REQ-024 ENABLE=0 SHALL freeze counter and index, drive all SEG_SELECT inactive and all HEX_OUT bits off from the next cycle; LOAD still accepted; scan resumes from frozen state on ENABLE=1.
REQ-025 Polarity SHALL be applied only at the output registers; ACTIVE_LOW=0 yields the bitwise inverse of ACTIVE_LOW=1 for every SEG_SELECT/HEX_OUT value.

Reset
REQ-026 RESET=1 SHALL immediately clear counter, index (0), active and pending buffers, pending flag and FRAME_DONE.
REQ-027 During reset SEG_SELECT and HEX_OUT SHALL be at the inactive/off level (all ones when ACTIVE_LOW=1).
REQ-028 Reset asserted mid-frame SHALL discard any pending LOAD; after release the first tick occurs REFRESH_DIV cycles later with index 0 displayed.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-029 Scan: ENABLE=1, no LOAD -> SEG_SELECT 1110,1101,1011,0111 each 4 cycles, HEX_OUT 0xC0 ("0"), FRAME_DONE every 16 cycles.
REQ-030 Load: LOAD DIGIT_IN=0x1234, DOT_IN=0 mid-frame -> current frame unchanged; after next boundary digit 0 shows 0x99 ("4"), digit 3 shows 0xF9 ("1").
REQ-031 Last-wins: LOAD 0x1111 then LOAD 0xABCD before boundary -> only 0xABCD displayed, digit 0 = 0xA1 ("d").
REQ-032 LZB=1, DIGIT_IN=0x0070, DOT_IN=0100 -> digit 3 HEX_OUT 0xFF, digit 2 0x7F (blank + dp), digit 1 0xF8 ("7"), digit 0 0xC0.
REQ-033 ENABLE low for 10 cycles mid-digit -> SEG_SELECT=1111, HEX_OUT=0xFF; on re-enable the same digit completes its remaining count.
REQ-034 RESET pulse mid-frame with pending LOAD -> outputs 1111/0xFF asynchronously, pending lost, display 0x0000 restarting at digit 0.
